// File: rtl/bmem_line_arbiter.sv
// bmem_line_arbiter: round-robin arbiter that serializes I/D cache-line transfers onto a 64-bit burst memory port
module bmem_line_arbiter #(
    parameter  int LOG2_LINEBITS = 10,
    localparam int LINEBITS      = 2 ** LOG2_LINEBITS,
    localparam int OFFBITS       = LOG2_LINEBITS - 3,
    localparam int CB            = LOG2_LINEBITS - 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         i_address,
    input  logic                i_read,
    output logic [LINEBITS-1:0] i_rdata,
    output logic                i_resp,
    input  logic [31:0]         d_address,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [LINEBITS-1:0] d_wdata,
    output logic [LINEBITS-1:0] d_rdata,
    output logic                d_resp,
    output logic [31:0]         bmem_address,
    output logic                bmem_read,
    output logic                bmem_write,
    output logic [63:0]         bmem_wdata,
    input  logic [63:0]         bmem_rdata,
    input  logic                bmem_resp,
    output logic [31:0]         perf_grant_i,
    output logic [31:0]         perf_grant_d
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t              state_q, state_d;
    logic [CB-1:0]       cnt_q, cnt_d;
    logic                last_q, last_d;
    logic                cli_q, cli_d;
    logic [31:0]         addr_q, addr_d;
    logic [LINEBITS-1:0] buf_q, buf_d;
    logic [LINEBITS-1:0] ird_q, ird_d;
    logic [LINEBITS-1:0] drd_q, drd_d;
    logic [31:0]         pi_q, pi_d;
    logic [31:0]         pd_q, pd_d;
    logic                req_i, req_d, grant_d, last_beat;
    logic [31:0]         sel_addr;

    assign req_i     = i_read;
    assign req_d     = d_read | d_write;
    assign grant_d   = req_d & (~req_i | ~last_q);
    assign sel_addr  = grant_d ? d_address : i_address;
    assign last_beat = bmem_resp && cnt_q == {CB{1'b1}};

    assign bmem_read    = state_q == READ;
    assign bmem_write   = state_q == WRITE;
    assign bmem_address = addr_q;
    assign bmem_wdata   = buf_q[{cnt_q, 6'd0} +: 64];
    assign i_resp       = state_q == DONE && !cli_q;
    assign d_resp       = state_q == DONE && cli_q;
    assign i_rdata      = ird_q;
    assign d_rdata      = drd_q;
    assign perf_grant_i = pi_q;
    assign perf_grant_d = pd_q;

    // next-state: grant in IDLE, move one beat per bmem_resp, publish read line on the last beat
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        cli_d   = cli_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        pi_d    = pi_q;
        pd_d    = pd_q;
        case (state_q)
            IDLE: if (req_i || req_d) begin
                cli_d   = grant_d;
                last_d  = grant_d;
                addr_d  = {sel_addr[31:OFFBITS], {OFFBITS{1'b0}}};
                state_d = (grant_d && d_write) ? WRITE : READ;
                buf_d   = (grant_d && d_write) ? d_wdata : buf_q;
                pi_d    = grant_d ? pi_q : pi_q + {31'd0, pi_q != 32'hFFFF_FFFF};
                pd_d    = grant_d ? pd_q + {31'd0, pd_q != 32'hFFFF_FFFF} : pd_q;
            end
            READ, WRITE: if (bmem_resp) begin
                if (state_q == READ) buf_d[{cnt_q, 6'd0} +: 64] = bmem_rdata;
                cnt_d   = cnt_q + CB'(1);
                state_d = last_beat ? DONE : state_q;
            end
            default: state_d = IDLE;
        endcase
        ird_d = (state_q == READ && last_beat && !cli_q) ? buf_d : ird_q;
        drd_d = (state_q == READ && last_beat && cli_q) ? buf_d : drd_q;
    end

    // state registers; reset aborts any burst and clears everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            cli_q   <= 1'b0;
            addr_q  <= '0;
            buf_q   <= '0;
            ird_q   <= '0;
            drd_q   <= '0;
            pi_q    <= '0;
            pd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            cli_q   <= cli_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            ird_q   <= ird_d;
            drd_q   <= drd_d;
            pi_q    <= pi_d;
            pd_q    <= pd_d;
        end
    end
endmodule

// File: tb/tb_bmem_line_arbiter.sv
// tb_bmem_line_arbiter: directed vector bench for the I/D burst line arbiter
module tb_bmem_line_arbiter;
    localparam int LB = 1024;
    localparam int BL = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   i_address = '0;
    logic          i_read = 1'b0;
    logic [LB-1:0] i_rdata;
    logic          i_resp;
    logic [31:0]   d_address = '0;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [LB-1:0] d_wdata = '0;
    logic [LB-1:0] d_rdata;
    logic          d_resp;
    logic [31:0]   bmem_address;
    logic          bmem_read;
    logic          bmem_write;
    logic [63:0]   bmem_wdata;
    logic [63:0]   bmem_rdata = '0;
    logic          bmem_resp = 1'b0;
    logic [31:0]   perf_grant_i;
    logic [31:0]   perf_grant_d;

    int errs = 0;
    int checks = 0;

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [31:0] addr;
        logic [63:0] base;
        int          stall_at;
        int          stall_len;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl[4];
    vec_t after_rst;

    bmem_line_arbiter #(.LOG2_LINEBITS(10)) dut (
        .clk(clk), .rst(rst),
        .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .bmem_address(bmem_address), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_rdata(bmem_rdata), .bmem_resp(bmem_resp),
        .perf_grant_i(perf_grant_i), .perf_grant_d(perf_grant_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_line(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        int bad;
        bad = -1;
        checks++;
        for (int k = 0; k < BL; k++)
            if (bad < 0 && act[k*64 +: 64] !== exp[k*64 +: 64]) bad = k;
        if (bad >= 0) begin
            errs++;
            $display("FAIL %s: beat %0d got %0h expected %0h", nm, bad, act[bad*64 +: 64], exp[bad*64 +: 64]);
        end
    endtask

    function automatic logic [LB-1:0] mk_line(input logic [63:0] base);
        logic [LB-1:0] l;
        for (int k = 0; k < BL; k++) l[k*64 +: 64] = base + 64'(k);
        return l;
    endfunction

    // called one cycle after the grant edge; returns at the DONE cycle
    task automatic run_burst(input bit wr, input logic [63:0] base, input int stall_at, input int stall_len);
        for (int k = 0; k < BL; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    bmem_resp  = 1'b0;
                    bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
                    @(negedge clk);
                    chk("stall_strobe", 64'(wr ? bmem_write : bmem_read), 64'd1);
                    if (wr) chk("stall_wdata", bmem_wdata, base + 64'(k));
                end
            end
            chk("beat_strobe", 64'(wr ? bmem_write : bmem_read), 64'd1);
            if (wr) chk("wbeat", bmem_wdata, base + 64'(k));
            bmem_resp  = 1'b1;
            bmem_rdata = base + 64'(k);
            @(negedge clk);
        end
        bmem_resp  = 1'b0;
        bmem_rdata = '0;
    endtask

    task automatic do_txn(input vec_t v);
        logic [LB-1:0] prev_i, prev_d;
        prev_i = i_rdata;
        prev_d = d_rdata;
        if (v.is_d) begin
            d_address = v.addr;
            d_read    = !v.wr;
            d_write   = v.wr;
            d_wdata   = v.wr ? mk_line(v.base) : '0;
        end else begin
            i_address = v.addr;
            i_read    = 1'b1;
        end
        @(negedge clk);
        chk("grant_addr", 64'(bmem_address), 64'(v.exp_addr));
        run_burst(v.wr, v.base, v.stall_at, v.stall_len);
        chk("done_strobe", 64'(bmem_read | bmem_write), 64'd0);
        chk("winner_resp", 64'(v.is_d ? d_resp : i_resp), 64'd1);
        chk("other_resp", 64'(v.is_d ? i_resp : d_resp), 64'd0);
        if (!v.wr) chk_line("rdata", v.is_d ? d_rdata : i_rdata, mk_line(v.base));
        else chk_line("d_rdata_hold", d_rdata, prev_d);
        chk_line("other_rdata_hold", v.is_d ? i_rdata : d_rdata, v.is_d ? prev_i : prev_d);
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        @(negedge clk);
        chk("resp_single", 64'(i_resp | d_resp), 64'd0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_strobes"}, 64'({bmem_read, bmem_write, i_resp, d_resp}), 64'd0);
        chk({nm, "_addr"}, 64'(bmem_address), 64'd0);
        chk({nm, "_wdata"}, bmem_wdata, 64'd0);
        chk_line({nm, "_i_rdata"}, i_rdata, '0);
        chk_line({nm, "_d_rdata"}, d_rdata, '0);
        chk({nm, "_perf"}, {perf_grant_i, perf_grant_d}, 64'd0);
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b0, 32'h6000_0044, 64'h0, -1, 0, 32'h6000_0000};
        tbl[1] = '{1'b1, 1'b1, 32'h8000_00FF, 64'hA5A5_0000_0000_0000, 8, 5, 32'h8000_0080};
        tbl[2] = '{1'b1, 1'b0, 32'h1234_5678, 64'h1111_0000_0000_0000, -1, 0, 32'h1234_5600};
        tbl[3] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 64'hBEEF_0000, 8, 5, 32'hFFFF_FF80};
        after_rst = '{1'b0, 1'b0, 32'h4000_0100, 64'h7700, -1, 0, 32'h4000_0100};

        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        i_address = 32'h0000_1000;
        d_address = 32'h0000_2040;
        i_read = 1'b1;
        d_read = 1'b1;
        @(negedge clk);
        chk("simul_first_addr", 64'(bmem_address), 64'h1000);
        run_burst(1'b0, 64'h100, -1, 0);
        chk("simul_i_resp", 64'({i_resp, d_resp}), 64'd2);
        chk_line("simul_i_rdata", i_rdata, mk_line(64'h100));
        i_read = 1'b0;
        @(negedge clk);
        chk("simul_idle", 64'({bmem_read, i_resp, d_resp}), 64'd0);
        @(negedge clk);
        chk("simul_second_addr", 64'(bmem_address), 64'h2000);
        run_burst(1'b0, 64'h200, -1, 0);
        chk("simul_d_resp", 64'({i_resp, d_resp}), 64'd1);
        chk_line("simul_d_rdata", d_rdata, mk_line(64'h200));
        d_read = 1'b0;
        @(negedge clk);
        chk("simul_perf", {perf_grant_i, perf_grant_d}, {32'd1, 32'd1});

        d_address = 32'h0000_3000;
        d_read = 1'b1;
        @(negedge clk);
        chk("b2b_grant1", 64'(bmem_address), 64'h3000);
        i_address = 32'h0000_4000;
        i_read = 1'b1;
        run_burst(1'b0, 64'h300, -1, 0);
        chk("b2b_resp1", 64'({i_resp, d_resp}), 64'd1);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_grant2", 64'(bmem_address), 64'h4000);
        run_burst(1'b0, 64'h400, -1, 0);
        chk("b2b_resp2", 64'({i_resp, d_resp}), 64'd2);
        i_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b2b_grant3", 64'(bmem_address), 64'h3000);
        run_burst(1'b0, 64'h500, -1, 0);
        chk("b2b_resp3", 64'({i_resp, d_resp}), 64'd1);
        d_read = 1'b0;
        @(negedge clk);
        chk("b2b_perf", {perf_grant_i, perf_grant_d}, {32'd2, 32'd3});

        for (int n = 0; n < 4; n++) do_txn(tbl[n]);
        chk("table_perf", {perf_grant_i, perf_grant_d}, {32'd4, 32'd5});

        i_address = 32'h4000_0100;
        i_read = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            bmem_resp = 1'b1;
            bmem_rdata = 64'(k + 1);
            @(negedge clk);
        end
        rst = 1'b0;
        i_read = 1'b0;
        bmem_resp = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_idle", 64'({bmem_read, bmem_write, i_resp, d_resp}), 64'd0);
        do_txn(after_rst);
        chk("after_rst_perf", {perf_grant_i, perf_grant_d}, {32'd1, 32'd0});

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
